// File: rtl/msg_assemble_pkg.sv
// Shared types and header field layout for the message assembler.
package msg_assemble_pkg;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_BODY,
    ST_HOLD,
    ST_DROP
  } state_e;

  localparam int unsigned HDR_FIELD_W       = 16;
  localparam int unsigned HDR_TOTAL_LSB     = 0;
  localparam int unsigned HDR_METHOD_LSB    = 16;
  localparam int unsigned MAX_WORDS_DEFAULT = 8;

endpackage

// File: rtl/msg_assemble_skid.sv
// One-entry {last, data} holding register; a load in the same cycle as a clear wins.
module msg_skid #(
  parameter int unsigned width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             last_i,
  input  logic [width-1:0] data_i,
  output logic             full_o,
  output logic             last_o,
  output logic [width-1:0] data_o
);

  logic             full_q, full_d;
  logic             last_q, last_d;
  logic [width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    last_d = last_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      last_d = last_i;
      data_d = data_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign last_o = last_q;
  assign data_o = data_q;

endmodule

// File: rtl/msg_assemble.sv
// Assembles header + payload beats into one message and hands it to a dispatcher.
module msg_assemble
  import msg_assemble_pkg::*;
#(
  parameter int unsigned width     = 32,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       EN_beat,
  input  logic [width-1:0]           beat_v,
  input  logic                       beat_last,
  output logic                       RDY_beat,
  input  logic                       RDY_message,
  output logic                       EN_message,
  output logic [15:0]                message_method,
  output logic [15:0]                message_count,
  output logic [MAX_WORDS*width-1:0] message_data,
  output logic [15:0]                err_count
);

  state_e                     state_q, state_d;
  logic [15:0]                idx_q, idx_d;
  logic [15:0]                exp_q, exp_d;
  logic [15:0]                method_q, method_d;
  logic [MAX_WORDS*width-1:0] data_q, data_d;
  logic [15:0]                err_q, err_d;
  logic                       err_ev;

  logic             skid_full, skid_last, skid_load, skid_clear;
  logic [width-1:0] skid_data;
  logic             proc_v, proc_last;
  logic [width-1:0] proc_data;
  logic [15:0]      hdr_total, hdr_method;

  msg_skid #(.width(width)) u_skid (
    .clk_i   (CLK),
    .rst_i   (nRST),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .last_i  (beat_last),
    .data_i  (beat_v),
    .full_o  (skid_full),
    .last_o  (skid_last),
    .data_o  (skid_data)
  );

  // A held beat is always consumed before any live beat once HOLD is left.
  always_comb begin
    skid_load  = EN_beat && ((state_q == ST_HOLD) || skid_full);
    skid_clear = (state_q != ST_HOLD) && skid_full;
    proc_v     = (state_q != ST_HOLD) && (skid_full || EN_beat);
    proc_last  = skid_full ? skid_last : beat_last;
    proc_data  = skid_full ? skid_data : beat_v;
    hdr_total  = proc_data[HDR_TOTAL_LSB +: HDR_FIELD_W];
    hdr_method = proc_data[HDR_METHOD_LSB +: HDR_FIELD_W];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    method_d = method_q;
    data_d   = data_q;
    err_ev   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (proc_v) begin
          method_d = hdr_method;
          exp_d    = hdr_total - 16'd1;
          idx_d    = '0;
          // A header claiming payload but flagged last is malformed as well.
          if ((hdr_total == 16'd0) || ((hdr_total - 16'd1) > 16'(MAX_WORDS)) ||
              ((hdr_total == 16'd1) != proc_last)) begin
            err_ev  = 1'b1;
            state_d = proc_last ? ST_HDR : ST_DROP;
          end else if (hdr_total == 16'd1) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (proc_v) begin
          for (int unsigned i = 0; i < MAX_WORDS; i++) begin
            if (idx_q == 16'(i)) data_d[i*width +: width] = proc_data;
          end
          idx_d = idx_q + 16'd1;
          if ((idx_q + 16'd1) == exp_q) begin
            if (proc_last) begin
              state_d = ST_HOLD;
            end else begin
              err_ev  = 1'b1;
              state_d = ST_DROP;
            end
          end else if (proc_last) begin
            err_ev  = 1'b1;
            state_d = ST_HDR;
          end
        end
      end
      ST_HOLD: begin
        if (RDY_message) state_d = ST_HDR;
      end
      ST_DROP: begin
        if (proc_v && proc_last) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
    if ((state_d == ST_HDR) || (state_d == ST_DROP)) data_d = '0;
    err_d = (err_ev && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q  <= ST_HDR;
      idx_q    <= '0;
      exp_q    <= '0;
      method_q <= '0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      method_q <= method_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign RDY_beat       = (state_q != ST_HOLD) && !skid_full;
  assign EN_message     = (state_q == ST_HOLD) && RDY_message;
  assign message_method = method_q;
  assign message_count  = exp_q;
  assign message_data   = data_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_msg_assemble.sv
// Scoreboard bench for msg_assemble: expected messages queued at stimulus time, popped on EN_message.
module tb_msg_assemble;

  localparam int unsigned W  = 32;
  localparam int unsigned MW = 8;

  typedef struct {
    logic [15:0]     method;
    logic [15:0]     count;
    logic [MW*W-1:0] data;
  } msg_t;

  logic            CLK = 1'b0;
  logic            nRST = 1'b1;
  logic            EN_beat = 1'b0;
  logic [W-1:0]    beat_v = '0;
  logic            beat_last = 1'b0;
  logic            RDY_beat;
  logic            RDY_message = 1'b1;
  logic            EN_message;
  logic [15:0]     msg_method;
  logic [15:0]     msg_count;
  logic [MW*W-1:0] msg_data;
  logic [15:0]     err_count;

  int   checks = 0;
  int   errors = 0;
  int   rx_cnt = 0;
  logic [15:0] exp_err = '0;
  msg_t sb[$];

  msg_assemble #(.width(W), .MAX_WORDS(MW)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .EN_beat        (EN_beat),
    .beat_v         (beat_v),
    .beat_last      (beat_last),
    .RDY_beat       (RDY_beat),
    .RDY_message    (RDY_message),
    .EN_message     (EN_message),
    .message_method (msg_method),
    .message_count  (msg_count),
    .message_data   (msg_data),
    .err_count      (err_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (EN_message === 1'b1) begin
      msg_t e;
      rx_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_msg: got method=%h count=%h, expected no message", msg_method, msg_count);
      end else begin
        e = sb.pop_front();
        if (msg_method !== e.method || msg_count !== e.count || msg_data !== e.data) begin
          errors++;
          $display("FAIL msg_content: got method=%h count=%h data=%h, expected method=%h count=%h data=%h",
                   msg_method, msg_count, msg_data, e.method, e.count, e.data);
        end
      end
    end
  end

  function automatic msg_t mk(input logic [15:0] m, input logic [15:0] c);
    msg_t r;
    r.method = m;
    r.count  = c;
    r.data   = '0;
    return r;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int n = 0;
    while (RDY_beat !== 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: RDY_beat=%b, expected 1 within 100 cycles", RDY_beat);
    end
    EN_beat = 1'b1; beat_v = d; beat_last = l;
    @(posedge CLK); #1;
    EN_beat = 1'b0; beat_last = 1'b0;
  endtask

  task automatic wait_msgs(input int target);
    int n = 0;
    while (rx_cnt < target && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (rx_cnt < target) begin
      errors++;
      $display("FAIL msg_timeout: received %0d messages, expected %0d", rx_cnt, target);
    end
  endtask

  task automatic check_err(input string name);
    checks++;
    if (err_count !== exp_err) begin
      errors++;
      $display("FAIL %s: err_count=%h, expected %h", name, err_count, exp_err);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (RDY_beat !== 1'b1 || EN_message !== 1'b0 || msg_data !== '0 ||
        msg_count !== 16'd0 || msg_method !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL %s: rdy=%b en=%b method=%h count=%h err=%h data=%h, expected 1 0 0 0 0 0",
               name, RDY_beat, EN_message, msg_method, msg_count, err_count, msg_data);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    EN_beat = 1'b1; beat_v = 32'h0001_0001; beat_last = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b0; EN_beat = 1'b0; beat_last = 1'b0;
    check_idle("reset_state");
    @(posedge CLK); #1;
    check_idle("reset_beat_ignored");
  endtask

  task automatic test_basic();
    msg_t e = mk(16'd5, 16'd2);
    e.data[0*W +: W] = 32'hA;
    e.data[1*W +: W] = 32'hB;
    sb.push_back(e);
    RDY_message = 1'b1;
    send_beat(32'h0005_0003, 1'b0);
    send_beat(32'h0000_000A, 1'b0);
    send_beat(32'h0000_000B, 1'b1);
    #4;
    checks++;
    if (EN_message !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: EN_message=%b one cycle after last, expected 1", EN_message);
    end
    @(negedge CLK);
    checks++;
    if (msg_data !== '0) begin
      errors++;
      $display("FAIL basic_buf_clear: data=%h after HOLD exit, expected 0", msg_data);
    end
    @(posedge CLK); #1;
    wait_msgs(1);
  endtask

  task automatic test_hold_skid();
    int base = rx_cnt;
    msg_t e = mk(16'd3, 16'd1);
    e.data[0 +: W] = 32'h55;
    sb.push_back(e);
    sb.push_back(mk(16'd7, 16'd0));
    RDY_message = 1'b0;
    send_beat(32'h0003_0002, 1'b0);
    send_beat(32'h0000_0055, 1'b1);
    EN_beat = 1'b1; beat_v = 32'h0007_0001; beat_last = 1'b1;
    @(posedge CLK); #1;
    EN_beat = 1'b0; beat_last = 1'b0;
    checks++;
    if (RDY_beat !== 1'b0 || EN_message !== 1'b0) begin
      errors++;
      $display("FAIL skid_full: RDY_beat=%b EN_message=%b, expected 0 0", RDY_beat, EN_message);
    end
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (RDY_beat !== 1'b0 || msg_method !== 16'd3 || msg_count !== 16'd1) begin
        errors++;
        $display("FAIL hold_stable: rdy=%b method=%h count=%h, expected 0 0003 0001", RDY_beat, msg_method, msg_count);
      end
    end
    RDY_message = 1'b1;
    wait_msgs(base + 2);
  endtask

  task automatic test_overlong();
    int base = rx_cnt;
    msg_t e = mk(16'd10, 16'd1);
    e.data[0 +: W] = 32'hDEAD;
    send_beat(32'h0001_0014, 1'b0);
    for (int i = 0; i < 19; i++) send_beat(32'(i), i == 18);
    exp_err = exp_err + 16'd1;
    check_err("overlong_err");
    sb.push_back(e);
    send_beat(32'h000A_0002, 1'b0);
    send_beat(32'h0000_DEAD, 1'b1);
    wait_msgs(base + 1);
  endtask

  task automatic test_early_last();
    int base = rx_cnt;
    msg_t e = mk(16'd9, 16'd2);
    e.data[0*W +: W] = 32'h1;
    e.data[1*W +: W] = 32'h2;
    send_beat(32'h0002_0004, 1'b0);
    send_beat(32'h0000_0011, 1'b0);
    send_beat(32'h0000_0022, 1'b1);
    exp_err = exp_err + 16'd1;
    check_err("early_last_err");
    sb.push_back(e);
    send_beat(32'h0009_0003, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    wait_msgs(base + 1);
    check_err("early_last_recover");
  endtask

  task automatic test_back_to_back();
    int base = rx_cnt;
    msg_t e = mk(16'h00C1, 16'd8);
    msg_t f = mk(16'h00C2, 16'd1);
    for (int i = 0; i < 8; i++) e.data[i*W +: W] = 32'hF000_0000 + 32'(i);
    f.data[0 +: W] = 32'h1234_5678;
    sb.push_back(e);
    sb.push_back(f);
    send_beat(32'h00C1_0009, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(32'hF000_0000 + 32'(i), i == 7);
    send_beat(32'h00C2_0002, 1'b0);
    send_beat(32'h1234_5678, 1'b1);
    wait_msgs(base + 2);
    check_err("max_words_no_err");
  endtask

  task automatic test_reset_mid();
    int base = rx_cnt;
    msg_t e = mk(16'd6, 16'd1);
    e.data[0 +: W] = 32'h77;
    send_beat(32'h0004_0004, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    send_beat(32'h0000_0002, 1'b0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    exp_err = '0;
    check_idle("reset_mid_state");
    sb.push_back(e);
    send_beat(32'h0006_0002, 1'b0);
    send_beat(32'h0000_0077, 1'b1);
    wait_msgs(base + 1);
    check_err("reset_mid_err");
  endtask

  task automatic test_saturate();
    dut.err_q = 16'hFFFE;
    exp_err = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h0000_0000, 1'b1);
      check_err("saturate");
    end
    repeat (2) @(posedge CLK);
    #1;
    check_err("saturate_hold");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_skid();
    test_overlong();
    test_early_last();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d messages outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
